// File: rtl/line_reverse_blkram.sv
// line_reverse_blkram: streaming line reverser built from two ping-pong banks.
// Each enabled cycle writes one word into the active bank. In the same cycle the
// other bank, which holds the previous line, is read back from the end.
// Optional feature macro: REV_MARK_EN adds the out_sol and out_eol marker outputs.
module line_reverse_blkram #(
  parameter int data_depth = 32,
  parameter int line_len   = 640,
  parameter int addr_w     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [data_depth-1:0] data_in,
  output logic                  out_valid,
  output logic [data_depth-1:0] data_out,
`ifdef REV_MARK_EN
  output logic                  out_sol,
  output logic                  out_eol,
`endif
  output logic                  primed
);

  localparam int STAGES = 1;
  localparam logic [addr_w-1:0] LAST = addr_w'(line_len - 1);

  logic [data_depth-1:0] mem0 [0:line_len-1];
  logic [data_depth-1:0] mem1 [0:line_len-1];

  logic [addr_w-1:0] col;
  logic [addr_w-1:0] raddr;
  logic              wbank;
  logic              wrap;
  logic [STAGES:0]   vld_pipe;

  // The read pointer mirrors the write pointer. col never exceeds LAST, so raddr cannot underflow.
  always_comb begin
    raddr       = LAST - col;
    wrap        = (col == LAST);
    vld_pipe[0] = en & primed;
  end

  // Column counter, bank select and primed flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col    <= '0;
      wbank  <= 1'b0;
      primed <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        col    <= '0;
        wbank  <= ~wbank;
        primed <= 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Bank writes. The RAM contents are deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && en) begin
      if (wbank) mem1[col] <= data_in;
      else       mem0[col] <= data_in;
    end
  end

  // Synchronous read of the bank not being written. The output holds through gaps.
  always_ff @(posedge clk) begin
    if (!rst_n)  data_out <= '0;
    else if (en) data_out <= wbank ? mem0[raddr] : mem1[raddr];
  end

  // Valid shift register: en & primed, delayed by one RAM read cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  assign out_valid = vld_pipe[STAGES];

`ifdef REV_MARK_EN
  // Line markers. They are aligned with data_out and qualified by valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_sol <= 1'b0;
      out_eol <= 1'b0;
    end else begin
      out_sol <= vld_pipe[0] & (raddr == LAST);
      out_eol <= vld_pipe[0] & (raddr == '0);
    end
  end
`endif

endmodule

// File: tb/tb_line_reverse_blkram.sv
// tb_line_reverse_blkram: directed test of line_reverse_blkram with line_len=8.
module tb_line_reverse_blkram;

  localparam int DW = 32;
  localparam int LL = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          out_valid;
  logic [DW-1:0] data_out;
  logic          primed;
`ifdef REV_MARK_EN
  logic          out_sol, out_eol;
`endif

  int n_chk = 0;
  int n_fail = 0;

  line_reverse_blkram #(.data_depth(DW), .line_len(LL), .addr_w(AW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in),
    .out_valid(out_valid), .data_out(data_out),
`ifdef REV_MARK_EN
    .out_sol(out_sol), .out_eol(out_eol),
`endif
    .primed(primed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle. The outputs are then sampled 1 time unit after the edge.
  task automatic step(input logic e, input logic [31:0] d);
    @(negedge clk);
    en = e;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic marks(input string tag, input logic s, input logic e);
`ifdef REV_MARK_EN
    chk({tag, "_sol"}, 32'(out_sol), 32'(s));
    chk({tag, "_eol"}, 32'(out_eol), 32'(e));
`endif
  endtask

  initial begin
    int k;
    logic [31:0] held;
    logic pat [10];

    // Reset
    rst_n = 1'b0;
    step(0, 0);
    step(0, 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_primed", 32'(primed), 0);
    chk("rst_data", data_out, 0);
    rst_n = 1'b1;

    // Line 0: no output is produced
    for (int i = 0; i < LL; i++) begin
      step(1, 32'(i));
      chk("l0_valid", 32'(out_valid), 0);
      if (i < LL - 1) chk("l0_primed_lo", 32'(primed), 0);
    end
    chk("l0_primed", 32'(primed), 1);

    // Line 1 continuous: reverses line 0
    for (int i = 0; i < LL; i++) begin
      step(1, 32'(10 + i));
      chk("l1_valid", 32'(out_valid), 1);
      chk("l1_data", data_out, 32'(7 - i));
      marks("l1", i == 0, i == LL - 1);
    end

    // Line 2 with gaps on cycles 3 and 6. The first output follows the 0 with no bubble.
    pat = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 1};
    k = 0;
    held = 0;
    for (int c = 0; c < 10; c++) begin
      if (pat[c]) begin
        step(1, 32'(20 + k));
        if (k == 0) chk("wrap_no_bubble", data_out, 17);
        chk("l2_valid", 32'(out_valid), 1);
        chk("l2_data", data_out, 32'(17 - k));
        marks("l2", k == 0, k == LL - 1);
        held = 32'(17 - k);
        k++;
      end else begin
        step(0, 32'hdead);
        chk("gap_valid", 32'(out_valid), 0);
        chk("gap_hold", data_out, held);
        marks("gap", 0, 0);
      end
    end

    // Gap at the wrap, then 4 words of line 3
    step(0, 0);
    chk("wrapgap_valid", 32'(out_valid), 0);
    chk("wrapgap_hold", data_out, 10);
    for (int i = 0; i < 4; i++) begin
      step(1, 32'(30 + i));
      chk("l3_data", data_out, 32'(27 - i));
    end

    // Reset in the middle of a line
    rst_n = 1'b0;
    step(0, 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_primed", 32'(primed), 0);
    rst_n = 1'b1;

    for (int i = 0; i < LL; i++) begin
      step(1, 32'(40 + i));
      chk("r0_valid", 32'(out_valid), 0);
    end
    chk("r0_primed", 32'(primed), 1);
    for (int i = 0; i < LL; i++) begin
      step(1, 32'(50 + i));
      chk("r1_valid", 32'(out_valid), 1);
      chk("r1_data", data_out, 32'(47 - i));
      marks("r1", i == 0, i == LL - 1);
    end
    step(0, 0);
    chk("end_valid", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
